// File: rtl/acq_pkg.sv
// Shared types and default widths for the acquisition window controller.
package acq_pkg;

   localparam int CNT_W_DEF  = 16;
   localparam int MISS_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_ACQ   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/acq_window_ctrl_if.sv
// Control/status bundle between the acquisition sequencer and its client.
interface acq_window_ctrl_if #(
   parameter int CNT_W  = acq_pkg::CNT_W_DEF,
   parameter int MISS_W = acq_pkg::MISS_W_DEF
);
   import acq_pkg::*;

   // Handshake: no back-pressure. Each *_pulse/sample_valid/clear_missed is a
   // single-cycle request sampled on the rising clk edge; every status output
   // is registered and is valid for the whole cycle after the edge that set it.
   logic              start_pulse;
   logic              abort_pulse;
   logic              sample_valid;
   logic [CNT_W-1:0]  delay_cfg;
   logic [CNT_W-1:0]  length_cfg;
   logic              clear_missed;
   logic              acq_enable;
   logic              busy;
   logic [CNT_W-1:0]  sample_index;
   logic              done_pulse;
   logic              aborted_pulse;
   logic [MISS_W-1:0] missed_count;
   state_e            state;

   modport master (
      output start_pulse, abort_pulse, sample_valid, delay_cfg, length_cfg, clear_missed,
      input  acq_enable, busy, sample_index, done_pulse, aborted_pulse, missed_count, state
   );

   modport slave (
      input  start_pulse, abort_pulse, sample_valid, delay_cfg, length_cfg, clear_missed,
      output acq_enable, busy, sample_index, done_pulse, aborted_pulse, missed_count, state
   );

endinterface

// File: rtl/acq_window_ctrl_sat_counter.sv
// Saturating event counter; a clear in the same cycle as an increment leaves 1.
module sat_counter #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [width-1:0] count
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= inc ? width'(1) : '0;
      end else if (inc && (count != '1)) begin
         count <= count + width'(1);
      end
   end

endmodule

// File: rtl/acq_window_ctrl.sv
// Trigger-delayed acquisition window sequencer with abort and missed-trigger count.
module acq_window_ctrl #(
   parameter int CNT_W  = acq_pkg::CNT_W_DEF,
   parameter int MISS_W = acq_pkg::MISS_W_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   acq_window_ctrl_if.slave   bus
);
   import acq_pkg::*;

   state_e            state, state_n;
   logic [CNT_W-1:0]  dly_q, dly_n;
   logic [CNT_W-1:0]  len_q, len_n;
   logic [CNT_W-1:0]  idx_q, idx_n;
   logic              abort_hit;
   logic              missed_inc;
   logic              acq_en_q;
   logic              busy_q;
   logic              done_q;
   logic              aborted_q;
   logic [MISS_W-1:0] missed_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         dly_q     <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         acq_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state     <= state_n;
         dly_q     <= dly_n;
         len_q     <= len_n;
         idx_q     <= idx_n;
         acq_en_q  <= (state_n == ST_ACQ);
         busy_q    <= (state_n != ST_IDLE);
         done_q    <= (state_n == ST_DONE);
         aborted_q <= abort_hit;
      end
   end

   always_comb begin
      state_n    = state;
      dly_n      = dly_q;
      len_n      = len_q;
      idx_n      = idx_q;
      abort_hit  = 1'b0;
      missed_inc = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start_pulse) begin
               dly_n = bus.delay_cfg;
               len_n = bus.length_cfg;
               idx_n = '0;
               if (bus.length_cfg == '0)     state_n = ST_DONE;
               else if (bus.delay_cfg != '0) state_n = ST_DELAY;
               else                          state_n = ST_ACQ;
            end
         end
         ST_DELAY: begin
            // dly_q holds the cycles still to wait including this one.
            dly_n = dly_q - CNT_W'(1);
            if (dly_q <= CNT_W'(1)) state_n = ST_ACQ;
         end
         ST_ACQ: begin
            if (bus.sample_valid) begin
               idx_n = idx_q + CNT_W'(1);
               if ((idx_q + CNT_W'(1)) == len_q) state_n = ST_DONE;
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
            idx_n   = '0;
         end
         default: state_n = ST_IDLE;
      endcase
      // Outside IDLE a trigger is counted as missed and abort overrides everything.
      if (state != ST_IDLE) begin
         missed_inc = bus.start_pulse;
         if (bus.abort_pulse) begin
            abort_hit = 1'b1;
            state_n   = ST_IDLE;
            idx_n     = '0;
         end
      end
   end

   sat_counter #(.width(MISS_W)) u_missed (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (missed_inc),
      .clr     (bus.clear_missed),
      .count   (missed_q)
   );

   assign bus.acq_enable    = acq_en_q;
   assign bus.busy          = busy_q;
   assign bus.sample_index  = idx_q;
   assign bus.done_pulse    = done_q;
   assign bus.aborted_pulse = aborted_q;
   assign bus.missed_count  = missed_q;
   assign bus.state         = state;

endmodule

// File: tb/tb_acq_window_ctrl.sv
// Directed scoreboard bench for acq_window_ctrl: every change of the status outputs is an event.
module tb_acq_window_ctrl;
   import acq_pkg::*;

   localparam int CNT_W  = 16;
   localparam int MISS_W = 8;
   localparam int SW     = 4 + CNT_W + MISS_W;
   localparam int W      = 16 + SW;

   logic clk;
   logic reset_n;
   int   cyc;
   int   t0;
   int   mon_mode;
   int   n_vec;
   int   n_fail;

   logic [W-1:0] exp_q[$];

   acq_window_ctrl_if #(.CNT_W(CNT_W), .MISS_W(MISS_W)) bus ();

   acq_window_ctrl #(.CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor / scoreboard
   logic [SW-1:0] snap;
   logic [SW-1:0] prev;
   logic [W-1:0]  e;
   logic [15:0]   rel;

   initial begin
      n_vec  = 0;
      n_fail = 0;
      prev   = '0;
   end

   always @(negedge clk) begin
      snap = {bus.acq_enable, bus.busy, bus.done_pulse, bus.aborted_pulse,
              bus.sample_index, bus.missed_count};
      rel  = 16'(cyc - t0);
      case (mon_mode)
         1: begin
            if (snap !== prev) begin
               prev = snap;
               n_vec++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_change rel=%0d got acq/busy/done/abort=%b idx=%0d missed=%0d required no change",
                           rel, snap[SW-1 -: 4], snap[CNT_W+MISS_W-1 -: CNT_W], snap[MISS_W-1:0]);
               end else begin
                  e = exp_q.pop_front();
                  if ({rel, snap} !== e) begin
                     n_fail++;
                     $display("FAIL event got rel=%0d acq/busy/done/abort=%b idx=%0d missed=%0d required rel=%0d acq/busy/done/abort=%b idx=%0d missed=%0d",
                              rel, snap[SW-1 -: 4], snap[CNT_W+MISS_W-1 -: CNT_W], snap[MISS_W-1:0],
                              e[W-1 -: 16], e[SW-1 -: 4], e[CNT_W+MISS_W-1 -: CNT_W], e[MISS_W-1:0]);
                  end
               end
            end
         end
         2: begin
            prev = snap;
            n_vec++;
            if ({snap, 2'(bus.state)} !== '0) begin
               n_fail++;
               $display("FAIL reset_idle got outputs=%h state=%0d required all zero, state IDLE",
                        snap, bus.state);
            end
         end
         3: begin
            while (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               n_vec++;
               n_fail++;
               $display("FAIL missing_event got none required rel=%0d acq/busy/done/abort=%b idx=%0d missed=%0d",
                        e[W-1 -: 16], e[SW-1 -: 4], e[CNT_W+MISS_W-1 -: CNT_W], e[MISS_W-1:0]);
            end
         end
         default: prev = snap;
      endcase
   end

   // driver tasks
   task automatic push_exp(int r, bit acq, bit bsy, bit dn, bit ab, int idx, int m);
      exp_q.push_back({16'(r), acq, bsy, dn, ab, CNT_W'(idx), MISS_W'(m)});
   endtask

   task automatic start_win(int d, int l);
      t0 = cyc;
      bus.delay_cfg   = CNT_W'(d);
      bus.length_cfg  = CNT_W'(l);
      bus.start_pulse = 1'b1;
      @(negedge clk);
      bus.start_pulse = 1'b0;
      // Config moves right after the trigger; the running window must not notice.
      bus.delay_cfg   = CNT_W'(7);
      bus.length_cfg  = CNT_W'(3);
   endtask

   task automatic go_to(int k);
      while (cyc - t0 < k) @(negedge clk);
   endtask

   task automatic finish_run();
      mon_mode = 3;
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   endtask

   task automatic drain(int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) finish_run();
      repeat (2) @(negedge clk);
   endtask

   // stimulus
   initial begin
      t0               = 0;
      mon_mode         = 2;
      reset_n          = 1'b1;
      bus.start_pulse  = 1'b0;
      bus.abort_pulse  = 1'b0;
      bus.sample_valid = 1'b0;
      bus.delay_cfg    = '0;
      bus.length_cfg   = '0;
      bus.clear_missed = 1'b0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      mon_mode = 1;

      // basic window, delay 3 length 4, samples every cycle
      bus.sample_valid = 1'b1;
      push_exp(1, 0, 1, 0, 0, 0, 0);
      push_exp(4, 1, 1, 0, 0, 0, 0);
      push_exp(5, 1, 1, 0, 0, 1, 0);
      push_exp(6, 1, 1, 0, 0, 2, 0);
      push_exp(7, 1, 1, 0, 0, 3, 0);
      push_exp(8, 0, 1, 1, 0, 4, 0);
      push_exp(9, 0, 0, 0, 0, 0, 0);
      start_win(3, 4);
      drain(50);
      bus.sample_valid = 1'b0;

      // sparse samples, delay 0 length 2
      push_exp(1, 1, 1, 0, 0, 0, 0);
      push_exp(4, 1, 1, 0, 0, 1, 0);
      push_exp(7, 0, 1, 1, 0, 2, 0);
      push_exp(8, 0, 0, 0, 0, 0, 0);
      start_win(0, 2);
      go_to(3); bus.sample_valid = 1'b1;
      go_to(4); bus.sample_valid = 1'b0;
      go_to(6); bus.sample_valid = 1'b1;
      go_to(7); bus.sample_valid = 1'b0;
      drain(50);

      // retrigger during ACQ, then clear_missed together with a 4th trigger
      bus.sample_valid = 1'b1;
      push_exp(1,  0, 1, 0, 0, 0, 0);
      push_exp(2,  1, 1, 0, 0, 0, 0);
      push_exp(3,  1, 1, 0, 0, 1, 0);
      push_exp(4,  1, 1, 0, 0, 2, 1);
      push_exp(5,  1, 1, 0, 0, 3, 2);
      push_exp(6,  1, 1, 0, 0, 4, 3);
      push_exp(7,  1, 1, 0, 0, 5, 1);
      push_exp(8,  0, 1, 1, 0, 6, 1);
      push_exp(9,  0, 0, 0, 0, 0, 1);
      push_exp(12, 0, 0, 0, 0, 0, 0);
      start_win(1, 6);
      go_to(3);  bus.start_pulse = 1'b1;
      go_to(6);  bus.clear_missed = 1'b1;
      go_to(7);  bus.start_pulse = 1'b0; bus.clear_missed = 1'b0;
      go_to(11); bus.clear_missed = 1'b1;
      go_to(12); bus.clear_missed = 1'b0;
      drain(50);

      // abort on the final sample
      push_exp(1, 1, 1, 0, 0, 0, 0);
      push_exp(2, 1, 1, 0, 0, 1, 0);
      push_exp(3, 1, 1, 0, 0, 2, 0);
      push_exp(4, 0, 0, 0, 1, 0, 0);
      push_exp(5, 0, 0, 0, 0, 0, 0);
      start_win(0, 3);
      go_to(3); bus.abort_pulse = 1'b1;
      go_to(4); bus.abort_pulse = 1'b0;
      drain(50);

      // zero length: straight to DONE, acq_enable never rises
      push_exp(1, 0, 1, 1, 0, 0, 0);
      push_exp(2, 0, 0, 0, 0, 0, 0);
      start_win(5, 0);
      drain(50);

      // abort in IDLE alongside start: start wins, one-sample window
      push_exp(1, 1, 1, 0, 0, 0, 0);
      push_exp(2, 0, 1, 1, 0, 1, 0);
      push_exp(3, 0, 0, 0, 0, 0, 0);
      bus.abort_pulse = 1'b1;
      start_win(0, 1);
      bus.abort_pulse = 1'b0;
      drain(50);
      bus.sample_valid = 1'b0;

      // abort together with a missed trigger in DELAY
      push_exp(1, 0, 1, 0, 0, 0, 0);
      push_exp(2, 0, 0, 0, 1, 0, 1);
      push_exp(3, 0, 0, 0, 0, 0, 1);
      push_exp(6, 0, 0, 0, 0, 0, 0);
      start_win(2, 5);
      go_to(1); bus.start_pulse = 1'b1; bus.abort_pulse = 1'b1;
      go_to(2); bus.start_pulse = 1'b0; bus.abort_pulse = 1'b0;
      go_to(5); bus.clear_missed = 1'b1;
      go_to(6); bus.clear_missed = 1'b0;
      drain(50);

      // missed_count saturates at 255 over 300 ignored triggers
      push_exp(1, 0, 1, 0, 0, 0, 0);
      for (int k = 1; k <= 255; k++) push_exp(1 + k, 0, 1, 0, 0, 0, k);
      push_exp(302, 0, 0, 0, 1, 0, 255);
      push_exp(303, 0, 0, 0, 0, 0, 255);
      push_exp(306, 0, 0, 0, 0, 0, 0);
      start_win(400, 1);
      go_to(1);   bus.start_pulse = 1'b1;
      go_to(301); bus.start_pulse = 1'b0; bus.abort_pulse = 1'b1;
      go_to(302); bus.abort_pulse = 1'b0;
      go_to(305); bus.clear_missed = 1'b1;
      go_to(306); bus.clear_missed = 1'b0;
      drain(1000);

      // reset in the middle of ACQ: outputs clear before the next clock edge
      bus.sample_valid = 1'b1;
      push_exp(1, 1, 1, 0, 0, 0, 0);
      push_exp(2, 1, 1, 0, 0, 1, 0);
      push_exp(3, 1, 1, 0, 0, 2, 0);
      push_exp(4, 1, 1, 0, 0, 3, 0);
      start_win(0, 10);
      go_to(4);
      @(posedge clk);
      #1;
      reset_n  = 1'b0;
      mon_mode = 2;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      mon_mode = 1;

      // first window after reset runs normally
      push_exp(1, 0, 1, 0, 0, 0, 0);
      push_exp(3, 1, 1, 0, 0, 0, 0);
      push_exp(4, 1, 1, 0, 0, 1, 0);
      push_exp(5, 0, 1, 1, 0, 2, 0);
      push_exp(6, 0, 0, 0, 0, 0, 0);
      start_win(2, 2);
      drain(50);
      bus.sample_valid = 1'b0;

      finish_run();
   end

endmodule

// File: doc/acq_window_ctrl.md
ACQ_WINDOW_CTRL -- requirements
Module: acq_window_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the width of delay, length and sample-index counters.
REQ-002 The block SHALL have parameter MISS_W, default 8, setting the width of the missed-trigger counter.
REQ-003 clk  in  1  sole clock, all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start_pulse  in  1  single-cycle trigger, already synchronised to clk by the upstream pulse-crossing stage.
REQ-006 abort_pulse  in  1  single-cycle request to cancel the running window.
REQ-007 sample_valid  in  1  one accepted sample per high cycle while acquiring.
REQ-008 delay_cfg  in  CNT_W  clk cycles from trigger to window open.
REQ-009 length_cfg  in  CNT_W  samples per window.
REQ-010 clear_missed  in  1  synchronous clear of missed_count.
REQ-011 acq_enable  out  1  high while window is open.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 sample_index  out  CNT_W  index of the next sample to accept, 0-based.
REQ-014 done_pulse  out  1  one-cycle completion strobe.
REQ-015 aborted_pulse  out  1  one-cycle abort strobe.
REQ-016 missed_count  out  MISS_W  saturating count of ignored triggers.

Function
REQ-017 The FSM SHALL have states IDLE, DELAY, ACQ and DONE, all outputs registered.
REQ-018 In IDLE, start_pulse SHALL latch delay_cfg and length_cfg; next state is DONE if length is 0, otherwise DELAY if delay is nonzero, otherwise ACQ.
REQ-019 Config changes after the trigger cycle SHALL NOT affect the running window.
REQ-020 DELAY SHALL last exactly delay_cfg cycles, so that with start sampled at cycle T acq_enable first reads high at T+1+delay_cfg.
REQ-021 In ACQ, acq_enable SHALL be high and each sample_valid SHALL increment sample_index.
REQ-022 The cycle that accepts sample number length_cfg SHALL move the FSM to DONE, and acq_enable SHALL be low from the next cycle.
REQ-023 sample_valid outside ACQ SHALL be ignored.
REQ-024 DONE SHALL last one cycle with done_pulse high, then return to IDLE with sample_index cleared to 0.
REQ-025 start_pulse in DELAY, ACQ or DONE SHALL be ignored and SHALL increment missed_count, saturating at 2^MISS_W-1.
REQ-026 abort_pulse in DELAY, ACQ or DONE SHALL force IDLE next cycle, raise aborted_pulse for one cycle, suppress done_pulse and clear sample_index.
REQ-027 abort_pulse in IDLE SHALL be ignored, and a simultaneous start_pulse SHALL be accepted.
REQ-028 If abort_pulse coincides with the final sample, abort SHALL win and done_pulse SHALL NOT fire.
REQ-029 If abort_pulse coincides with a start_pulse that counts as missed, both actions SHALL take effect.
REQ-030 clear_missed SHALL zero missed_count, and if it coincides with a missed trigger the result SHALL be 1.
REQ-031 sample_index SHALL NOT wrap within a window, since length is at most 2^CNT_W-1.

Reset
REQ-032 Asserting reset_n low SHALL immediately force state IDLE, all counters and latched config to 0, and all outputs to 0.
REQ-033 Reset SHALL abandon a window mid-operation without producing done_pulse or aborted_pulse.
REQ-034 After reset release, the first start_pulse SHALL be accepted normally.

Structure
REQ-035 Package acq_pkg SHALL hold the state enumeration and the default CNT_W and MISS_W constants.
REQ-036 The missed-trigger counter SHALL be a sub-module sat_counter with parameter width and inputs inc and clr, where clr wins but combines with inc as in REQ-030.
REQ-037 The expected RTL size SHALL be 150-250 lines.

Verification
REQ-038 Basic window: delay_cfg=3, length_cfg=4, start at T, sample_valid always high -> acq_enable high T+4..T+7, done_pulse at T+8, busy low at T+9.
REQ-039 Sparse samples: delay_cfg=0, length_cfg=2, sample_valid at T+3 and T+6 -> acq_enable high T+1..T+6, done_pulse at T+7.
REQ-040 Retrigger: 3 start_pulses during ACQ followed by clear_missed coincident with a 4th -> missed_count 3, then 1, with the window unaffected.
REQ-041 Abort: abort_pulse on the cycle of the final sample -> aborted_pulse, no done_pulse, and sample_index is 0 next cycle.
REQ-042 Zero length: length_cfg=0 -> done_pulse at T+1 and acq_enable never high.
REQ-043 Reset mid-ACQ: reset_n low for 2 cycles -> all outputs 0 immediately, and a subsequent start runs a normal window.
